// File: rtl/rns_to_int_seq_64_pkg.sv
// Shared definitions for the bit-serial RNS-to-integer converter.
// The 9-channel format has channel 0 = 1 bit (modulus 2) and channels 1..8 =
// 8 bits each, with pairwise coprime moduli. The CRT weights A0..A8 are
// derived at elaboration time from the modulus table, so the moduli table is
// the only place the number format is defined.
package rns_to_int_seq_64_pkg;

    localparam int CH_NUM = 9;
    localparam int ACC_W  = 66;   // holds 2*M without overflow
    localparam int RNS_W  = 65;
    localparam int INT_W  = 64;

    typedef logic [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BIT  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int unsigned CH_MOD   [CH_NUM] = '{2, 255, 253, 251, 247, 241, 239, 233, 229};
    localparam int unsigned CH_WIDTH [CH_NUM] = '{1, 8, 8, 8, 8, 8, 8, 8, 8};

    function automatic acc_t calc_m();
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < CH_NUM; i++) p = p * 128'(CH_MOD[i]);
        return acc_t'(p);
    endfunction

    localparam acc_t MAX_NUM_64 = calc_m();

    // CRT weight: A_i = M_i * (M_i^-1 mod m_i) mod M, with M_i = M / m_i.
    function automatic acc_t calc_a(input int i);
        logic [127:0] mi, mm, prod;
        int unsigned  inv;
        mi  = 128'(MAX_NUM_64) / 128'(CH_MOD[i]);
        mm  = mi % 128'(CH_MOD[i]);
        inv = 0;
        for (int x = 1; x < 256; x++)
            if (inv == 0 && ((mm * 128'(x)) % 128'(CH_MOD[i])) == 128'd1) inv = x;
        prod = (mi * 128'(inv)) % 128'(MAX_NUM_64);
        return acc_t'(prod);
    endfunction

    localparam acc_t A0 = calc_a(0);
    localparam acc_t A1 = calc_a(1);
    localparam acc_t A2 = calc_a(2);
    localparam acc_t A3 = calc_a(3);
    localparam acc_t A4 = calc_a(4);
    localparam acc_t A5 = calc_a(5);
    localparam acc_t A6 = calc_a(6);
    localparam acc_t A7 = calc_a(7);
    localparam acc_t A8 = calc_a(8);

    // Values at or above 2^63 are the RNS images of negative integers
    // (M + x); adding 2^64 - M (mod 2^66) and truncating recovers x.
    localparam acc_t RNS_MIDDLE_POINT_64 = acc_t'(1) << 63;
    localparam acc_t INT_RNS_DELTA_64    = (acc_t'(1) << 64) - MAX_NUM_64;

    function automatic acc_t a_of(input logic [3:0] ch);
        case (ch)
            4'd0:    return A0;
            4'd1:    return A1;
            4'd2:    return A2;
            4'd3:    return A3;
            4'd4:    return A4;
            4'd5:    return A5;
            4'd6:    return A6;
            4'd7:    return A7;
            4'd8:    return A8;
            default: return '0;
        endcase
    endfunction

    // Index of the MSB within a channel (first bit processed).
    function automatic logic [2:0] ch_msb(input logic [3:0] ch);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < CH_NUM; i++)
            if (ch == 4'(i)) r = 3'(CH_WIDTH[i] - 1);
        return r;
    endfunction

    // Bit position of a channel's LSB inside the packed rns word.
    function automatic logic [6:0] ch_lsb(input logic [3:0] ch);
        logic [6:0] pos;
        pos = '0;
        for (int i = 0; i < CH_NUM; i++)
            if (4'(i) < ch) pos = pos + 7'(CH_WIDTH[i]);
        return pos;
    endfunction

endpackage

// File: rtl/rns_to_int_seq_64_step.sv
// One bit-serial modular multiply-accumulate step (combinational).
//   p_next   = (2*x + bit_in*a) mod M
//   acc_next = add_acc ? (acc + p_next) mod M : acc
// Ports: x, a, acc (< M), bit_in, add_acc in; p_next, acc_next out.
// All inputs below M keep every intermediate below 2M, so one conditional
// subtract per addition is enough.
module rns_modadd_step
    import rns_to_int_seq_64_pkg::*;
(
    input  acc_t x,
    input  logic bit_in,
    input  acc_t a,
    input  logic add_acc,
    input  acc_t acc,
    output acc_t p_next,
    output acc_t acc_next
);

    function automatic acc_t cond_sub(input acc_t v);
        return (v >= MAX_NUM_64) ? v - MAX_NUM_64 : v;
    endfunction

    acc_t dbl_r, sum_r;

    always_comb begin
        dbl_r    = cond_sub(x << 1);
        sum_r    = cond_sub(dbl_r + (bit_in ? a : '0));
        p_next   = sum_r;
        acc_next = add_acc ? cond_sub(acc + sum_r) : acc;
    end

endmodule

// File: rtl/rns_to_int_seq_64.sv
// Multi-cycle RNS-to-integer converter for the 9-channel 64-bit RNS format.
// Walks the captured residues one bit per cycle (channel 0..8, MSB first),
// building A_ch*r_ch mod M in P and folding it into ACC at each channel LSB,
// then maps ACC back to two's complement.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     operand handshake, rns[64:0] packed residues
//   out_valid/out_ready   result handshake, int_number[63:0]
//   busy                  high whenever not IDLE
// Latency: 66 edges from acceptance to out_valid; 68 cycles per result.
module rns_to_int_seq_64
    import rns_to_int_seq_64_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RNS_W-1:0] rns,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] int_number,
    output logic             busy
);

    state_t           state, state_nx;
    logic             rst_done;   // keeps in_ready low until the first edge after reset
    logic [RNS_W-1:0] rns_q;
    logic [3:0]       ch_q;
    logic [2:0]       bit_q;
    acc_t             p_q, acc_q;
    logic [INT_W-1:0] int_q;

    logic             cur_bit, last_bit, last_all, accept;
    acc_t             p_nx, acc_nx, fix_val;

    assign cur_bit  = rns_q[ch_lsb(ch_q) + 7'(bit_q)];
    assign last_bit = (bit_q == 3'd0);
    assign last_all = last_bit && (ch_q == 4'(CH_NUM - 1));
    assign accept   = in_valid && in_ready;
    assign fix_val  = (acc_q >= RNS_MIDDLE_POINT_64) ? acc_q + INT_RNS_DELTA_64 : acc_q;

    rns_modadd_step u_step (
        .x        (p_q),
        .bit_in   (cur_bit),
        .a        (a_of(ch_q)),
        .add_acc  (last_bit),
        .acc      (acc_q),
        .p_next   (p_nx),
        .acc_next (acc_nx)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept) state_nx = ST_BIT;
            ST_BIT:  if (last_all) state_nx = ST_FIX;
            ST_FIX:  state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state == ST_IDLE) && rst_done;
        out_valid = (state == ST_DONE);
        busy      = (state != ST_IDLE);
    end

    assign int_number = int_q;

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_done <= 1'b0;
            rns_q    <= '0;
            ch_q     <= '0;
            bit_q    <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            int_q    <= '0;
        end else begin
            rst_done <= 1'b1;
            case (state)
                ST_IDLE: if (accept) begin
                    rns_q <= rns;
                    ch_q  <= '0;
                    bit_q <= ch_msb(4'd0);
                    p_q   <= '0;
                    acc_q <= '0;
                end
                ST_BIT: begin
                    acc_q <= acc_nx;
                    if (last_bit) begin
                        p_q   <= '0;
                        ch_q  <= ch_q + 4'd1;
                        bit_q <= ch_msb(ch_q + 4'd1);
                    end else begin
                        p_q   <= p_nx;
                        bit_q <= bit_q - 3'd1;
                    end
                end
                ST_FIX:  int_q <= INT_W'(fix_val);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rns_to_int_seq_64.sv
// Self-checking bench: integers are encoded to residues with plain modular
// arithmetic and the converter must hand back the original integer.
module tb_rns_to_int_seq_64;

    localparam int unsigned MODS [9] = '{2, 255, 253, 251, 247, 241, 239, 233, 229};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [64:0] rns;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] int_number;
    logic        busy;

    int checks = 0;
    int errors = 0;
    logic [127:0] big_m;

    always #5 clk = ~clk;

    rns_to_int_seq_64 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rns        (rns),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .int_number (int_number),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Two's-complement x maps to x mod M (negatives become M + x).
    function automatic logic [64:0] to_rns(input logic [63:0] x);
        logic [127:0] v;
        logic [64:0]  r;
        v = {64'd0, x};
        if (x[63]) v = v + big_m - (128'd1 << 64);
        r[0] = 1'(v % 128'(MODS[0]));
        for (int i = 1; i < 9; i++) r[8*i -: 8] = 8'(v % 128'(MODS[i]));
        return r;
    endfunction

    function automatic logic [64:0] rand_rns();
        logic [95:0] rr;
        rr = {$urandom, $urandom, $urandom};
        return rr[64:0];
    endfunction

    task automatic convert(input logic [63:0] x, input int hold, input bit scramble);
        int edges;
        @(negedge clk);
        check("in_ready_before", 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        rns       = to_rns(x);
        out_ready = (hold == 0);
        @(posedge clk);            // acceptance edge
        @(negedge clk);
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 200) begin
            if (scramble) rns = rand_rns();
            if (edges == 30) begin
                check("busy_in_bit", 64'(busy), 64'd1);
                check("in_ready_in_bit", 64'(in_ready), 64'd0);
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        check("latency", 64'(edges), 64'd66);
        if (!out_valid) return;
        check("result", int_number, x);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            rns      = rand_rns();
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_value", int_number, x);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);            // output handshake
        @(negedge clk);
        check("out_valid_after", 64'(out_valid), 64'd0);
        check("in_ready_after", 64'(in_ready), 64'd1);
    endtask

    initial begin
        big_m = 128'd1;
        for (int i = 0; i < 9; i++) big_m = big_m * 128'(MODS[i]);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rns       = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_int", int_number, 64'd0);

        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_int", int_number, 64'd0);

        convert(64'd0, 0, 1'b0);
        convert(64'd1, 0, 1'b0);
        convert(64'd12345, 0, 1'b0);
        convert(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
        convert(64'h8000_0000_0000_0000, 0, 1'b0);
        convert(64'h7FFF_FFFF_FFFF_FFFF, 0, 1'b0);
        convert({$urandom, $urandom}, 10, 1'b0);
        convert({$urandom, $urandom}, 0, 1'b1);
        for (int k = 0; k < 6; k++) convert({$urandom, $urandom}, k % 3, k[0]);

        // Reset in the middle of BIT
        @(negedge clk);
        in_valid = 1'b1;
        rns      = to_rns({$urandom, $urandom});
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (29) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_int", int_number, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        convert(64'd123456789, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rns_to_int_seq_64.md
Name: rns_to_int_seq_64

Overview:
- Multi-cycle, area-reduced controller for RNS-to-integer reconstruction on the 9-channel 64-bit RNS format.
- Replaces the wide single-cycle CRT multiply/modulo with a bit-serial modular multiply-accumulate sequenced by an FSM.
- Sits between RNS arithmetic units and integer consumers.
- Uses valid/ready handshakes on both sides.

Parameters:
- CH_NUM, 9, number of RNS channels (channel 0 is 1 bit, modulus `B0; channels 1..8 are 8 bits, moduli `B1..`B8).
- ACC_W, 66, internal accumulator width; must hold 2*`MAX_NUM_64 without overflow.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  rns holds a valid operand.
- in_ready  output  1  block can accept an operand.
- rns  input  65  packed residues: [0:0] ch0, [8:1] ch1, ..., [64:57] ch8.
- out_valid  output  1  int_number is valid.
- out_ready  input  1  consumer accepts the result.
- int_number  output  64  reconstructed two's-complement integer.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset is asynchronous and active-low. It does not depend on clk.
- Reset values:
  - in_ready=0 while reset is asserted, 1 on the first cycle after release.
  - out_valid=0, int_number=0, busy=0.
  - All internal registers are 0. FSM state is IDLE.
- FSM states are IDLE, BIT, FIX and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register rns. Set ch=0, bit index=0 (ch0 has one bit), P=0, ACC=0. Go to BIT.
- BIT (one residue bit per cycle, MSB first within each channel, channels 0..8 in order):
  - Compute P' = 2P mod M, with one conditional subtract of M = `MAX_NUM_64.
  - If the current bit is 1, P' = P' + A_ch mod M, with one conditional subtract. A_ch is `A0..`A8.
  - On the channel's last bit (LSB), ACC = ACC + P' mod M, with one conditional subtract, and P resets to 0. Otherwise P = P'.
  - Advance the bit and channel counters.
  - After ch8 bit 0, go to FIX.
  - Channel 0 takes 1 cycle and channels 1..8 take 8 cycles each, so BIT lasts exactly 65 cycles.
- FIX:
  - int_number = (ACC >= `RNS_MIDDLE_POINT_64) ? ACC + `INT_RNS_DELTA_64 : ACC, truncated to 64 bits.
  - Go to DONE.
- DONE:
  - out_valid=1. int_number is held stable until out_valid&&out_ready.
  - On the handshake, clear out_valid and go to IDLE. in_ready=1 on the next cycle.
- Latency:
  - Acceptance edge at T.
  - out_valid is high after edge T+66: 65 BIT edges plus 1 FIX edge.
  - With out_ready tied high, back-to-back throughput is one result per 68 cycles.
- in_ready=0 in BIT, FIX and DONE. in_valid is ignored there and rns is not sampled.
- The captured rns copy is used throughout, so changes on the rns input after acceptance have no effect.
- Modular invariants: P, P' and ACC are always < M after every update. Every conditional subtract is a single compare against M on ACC_W bits.
- Residues are assumed canonical (< modulus). A non-canonical residue still yields a result ≡ Σ A_i·r_i mod M. There is no error flag.
- out_ready is ignored outside DONE.
- Reset asserted mid-operation: state returns to IDLE immediately, out_valid drops, and the partial result is discarded.

Decomposition:
- Shared package holds:
  - constants M (`MAX_NUM_64), A0..A8, RNS_MIDDLE_POINT_64 and INT_RNS_DELTA_64, all as ACC_W-bit localparams;
  - channel width table {1,8,8,8,8,8,8,8,8};
  - FSM state enum type.
- Sub-module rns_modadd_step:
  - Combinational (2x+bit·a) mod M, then optional +acc mod M.
  - Three chained conditional subtracts.
  - Verified standalone.

Test Plan:
- Reset then idle -> in_ready=1, out_valid=0, int_number=0, busy=0; no activity with in_valid=0.
- rns for integer 0 (all residues 0), out_ready=1 -> out_valid high exactly 66 edges after acceptance, int_number=0; in_ready returns the cycle after the output handshake.
- rns for 1 (all residues 1) -> 1. Residues of 12345 -> 12345. Residues produced by the int-to-RNS conversion of 0xFFFF_FFFF_FFFF_FFFF -> int_number=0xFFFF_FFFF_FFFF_FFFF (negative path through FIX).
- Result ready with out_ready=0 for 10 cycles -> out_valid and int_number stay stable; in_valid pulses during that time are not accepted; the result is consumed when out_ready=1.
- Change rns input every cycle during BIT -> result equals conversion of the operand captured at acceptance.
- rst_n asserted at BIT cycle 30 -> out_valid=0 and busy=0 immediately; after release, a fresh operand (123456789) converts correctly with full latency.
